// File: rtl/alu_pkg.sv
// ALU op codes, the overflow cause code and the result-stage FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_NOR = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_SUB = 3'd6;

  localparam logic [4:0] CAUSE_OV = 5'd12;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_e;

  // Only signed ADD/SUB can trap; overflow on any other op is meaningless.
  function automatic logic is_trap(logic [2:0] op, logic overflow, logic unsig);
    return overflow & ~unsig & ((op == ALU_ADD) | (op == ALU_SUB));
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// EX->MEM result-stage bundle: ALU outputs + side-band in, buffered entry + exception out.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs on each side.
// Ports: master = EX/MEM/handler side, slave = alu_result_stage.
interface alu_result_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] aluout;
  logic              overflow;
  logic              compout;
  logic [2:0]        op;
  logic              unsig;
  logic              is_slt;
  logic [DATA_W-1:0] pc;
  logic [REG_W-1:0]  rd;
  logic              reg_write;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_rd;
  logic              out_reg_write;
  logic              exc_valid;
  logic [DATA_W-1:0] exc_epc;
  logic [4:0]        exc_cause;
  logic              exc_ack;

  modport master (
    output in_valid, aluout, overflow, compout, op, unsig, is_slt, pc, rd, reg_write,
           flush, out_ready, exc_ack,
    input  in_ready, out_valid, out_result, out_rd, out_reg_write,
           exc_valid, exc_epc, exc_cause
  );

  modport slave (
    input  in_valid, aluout, overflow, compout, op, unsig, is_slt, pc, rd, reg_write,
           flush, out_ready, exc_ack,
    output in_ready, out_valid, out_result, out_rd, out_reg_write,
           exc_valid, exc_epc, exc_cause
  );
endinterface

// File: rtl/alu_result_stage_skid_buf2.sv
// Two-entry FIFO skid buffer with synchronous flush.
// Latency: 1 cycle push-to-pop when empty.
// Backpressure: push_rdy_o low when full; entry held until pop_rdy_i.
// Ports: push_vld_i/push_rdy_o/push_dat_i, pop_vld_o/pop_rdy_i/pop_dat_o, flush_i.
module skid_buf2 #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         push_vld_i,
  output logic         push_rdy_o,
  input  logic [W-1:0] push_dat_i,
  output logic         pop_vld_o,
  input  logic         pop_rdy_i,
  output logic [W-1:0] pop_dat_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign push_rdy_o = (cnt_q != 2'd2);
  assign pop_vld_o  = (cnt_q != 2'd0);
  assign pop_dat_o  = mem_q[rd_ptr_q];

  // Flush overrides both sides: nothing enters, nothing leaves.
  assign push = push_vld_i & push_rdy_o & ~flush_i;
  assign pop  = pop_vld_o & pop_rdy_i & ~flush_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// EX/MEM register: selects SLT/ALU result, detects signed ADD/SUB overflow trap, buffers entries.
// Latency: 1 cycle when the buffer is empty.
// Backpressure: in_ready low when buffer full or an exception is pending (TRAP).
// Ports: clk, reset_n (async active-low), bus (alu_result_stage_if.slave).
module alu_result_stage #(
  parameter int         DATA_W   = 32,
  parameter int         REG_W    = 5,
  parameter logic [4:0] CAUSE_OV = alu_pkg::CAUSE_OV
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_result_stage_if.slave   bus
);
  import alu_pkg::*;

  localparam int ENTRY_W = DATA_W + REG_W + 1;

  state_e            state_q, state_d;
  logic              exc_valid_q, exc_valid_d;
  logic [DATA_W-1:0] exc_epc_q, exc_epc_d;
  logic [4:0]        exc_cause_q, exc_cause_d;

  logic              buf_push_rdy;
  logic              run;
  logic              accept;
  logic              trap;
  logic [DATA_W-1:0] result;
  logic [ENTRY_W-1:0] entry_in, entry_out;

  assign run    = (state_q == RUN);
  assign trap   = is_trap(bus.op, bus.overflow, bus.unsig);
  assign result = bus.is_slt ? {{(DATA_W-1){1'b0}}, bus.compout} : bus.aluout;

  assign bus.in_ready = buf_push_rdy & run;
  // A flushed input is dropped, so it must not raise an exception either.
  assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

  // Trapping instruction still flows to MEM, but must not write its rd.
  assign entry_in = {result, bus.rd, bus.reg_write & ~trap};

  skid_buf2 #(.W(ENTRY_W)) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (bus.flush),
    .push_vld_i (bus.in_valid & run),
    .push_rdy_o (buf_push_rdy),
    .push_dat_i (entry_in),
    .pop_vld_o  (bus.out_valid),
    .pop_rdy_i  (bus.out_ready),
    .pop_dat_o  (entry_out)
  );

  assign bus.out_result    = entry_out[ENTRY_W-1 -: DATA_W];
  assign bus.out_rd        = entry_out[REG_W:1];
  assign bus.out_reg_write = entry_out[0];

  always_comb begin
    state_d     = state_q;
    exc_valid_d = exc_valid_q;
    exc_epc_d   = exc_epc_q;
    exc_cause_d = exc_cause_q;
    unique case (state_q)
      RUN: begin
        if (accept && trap) begin
          state_d     = TRAP;
          exc_valid_d = 1'b1;
          exc_epc_d   = bus.pc;
          exc_cause_d = CAUSE_OV;
        end
      end
      TRAP: begin
        // Input is blocked here, so no new trap can race the acknowledge.
        if (bus.exc_ack) begin
          state_d     = RUN;
          exc_valid_d = 1'b0;
          exc_epc_d   = '0;
          exc_cause_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      exc_valid_q <= 1'b0;
      exc_epc_q   <= '0;
      exc_cause_q <= '0;
    end else begin
      state_q     <= state_d;
      exc_valid_q <= exc_valid_d;
      exc_epc_q   <= exc_epc_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  assign bus.exc_valid = exc_valid_q;
  assign bus.exc_epc   = exc_epc_q;
  assign bus.exc_cause = exc_cause_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
// Latency: n/a.
// Backpressure: driven directly via out_ready.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

  alu_result_stage #(.DATA_W(32), .REG_W(5), .CAUSE_OV(5'd12)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.aluout    = '0;
    bus.overflow  = 1'b0;
    bus.compout   = 1'b0;
    bus.op        = ALU_AND;
    bus.unsig     = 1'b0;
    bus.is_slt    = 1'b0;
    bus.pc        = '0;
    bus.rd        = '0;
    bus.reg_write = 1'b0;
    bus.flush     = 1'b0;
    bus.exc_ack   = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] alu, input logic ov,
                       input logic cmp, input logic uns, input logic slt,
                       input logic [31:0] pc, input logic [4:0] rd);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.aluout    = alu;
    bus.overflow  = ov;
    bus.compout   = cmp;
    bus.unsig     = uns;
    bus.is_slt    = slt;
    bus.pc        = pc;
    bus.rd        = rd;
    bus.reg_write = 1'b1;
  endtask

  initial begin
    idle();
    bus.out_ready = 1'b1;
    reset_n = 1'b0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check("rst_out_rw", 32'(bus.out_reg_write), 32'd0);
    check("rst_exc_valid", 32'(bus.exc_valid), 32'd0);
    check("rst_exc_epc", bus.exc_epc, 32'd0);
    check("rst_exc_cause", 32'(bus.exc_cause), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // 1: plain ADD, one-cycle latency
    drive(ALU_ADD, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 5'd3);
    tick();
    bus.in_valid = 1'b0;
    check("add_out_valid", 32'(bus.out_valid), 32'd1);
    check("add_result", bus.out_result, 32'd5);
    check("add_rd", 32'(bus.out_rd), 32'd3);
    check("add_rw", 32'(bus.out_reg_write), 32'd1);
    tick();
    check("add_drained", 32'(bus.out_valid), 32'd0);

    // 2: SLT selects compout
    drive(ALU_SUB, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 5'd4);
    tick();
    bus.in_valid = 1'b0;
    check("slt1_result", bus.out_result, 32'h0000_0001);
    drive(ALU_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0108, 5'd4);
    tick();
    bus.in_valid = 1'b0;
    check("slt0_result", bus.out_result, 32'h0000_0000);
    tick();

    // 3: signed ADD overflow traps
    drive(ALU_ADD, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 5'd7);
    tick();
    bus.in_valid = 1'b0;
    check("ov_exc_valid", 32'(bus.exc_valid), 32'd1);
    check("ov_exc_epc", bus.exc_epc, 32'h0040_0010);
    check("ov_exc_cause", 32'(bus.exc_cause), 32'd12);
    check("ov_out_valid", 32'(bus.out_valid), 32'd1);
    check("ov_rw_forced0", 32'(bus.out_reg_write), 32'd0);
    check("ov_in_ready", 32'(bus.in_ready), 32'd0);
    drive(ALU_OR, 32'h0000_00AA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0014, 5'd9);
    tick();
    check("trap_in_ready", 32'(bus.in_ready), 32'd0);
    check("trap_exc_hold", 32'(bus.exc_valid), 32'd1);
    tick();
    check("trap_blocked", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    bus.exc_ack = 1'b1;
    tick();
    bus.exc_ack = 1'b0;
    check("ack_exc_valid", 32'(bus.exc_valid), 32'd0);
    check("ack_in_ready", 32'(bus.in_ready), 32'd1);

    drive(ALU_ADD, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0018, 5'd7);
    tick();
    bus.in_valid = 1'b0;
    check("addu_no_exc", 32'(bus.exc_valid), 32'd0);
    check("addu_rw", 32'(bus.out_reg_write), 32'd1);
    check("addu_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive(ALU_XOR, 32'h0000_0F0F, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_001C, 5'd8);
    tick();
    bus.in_valid = 1'b0;
    check("xor_no_exc", 32'(bus.exc_valid), 32'd0);
    check("xor_rw", 32'(bus.out_reg_write), 32'd1);
    check("xor_result", bus.out_result, 32'h0000_0F0F);
    tick();

    // 4: backpressure, FIFO order
    bus.out_ready = 1'b0;
    drive(ALU_ADD, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 5'd1);
    tick();
    check("bp_ready_cnt1", 32'(bus.in_ready), 32'd1);
    drive(ALU_ADD, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 5'd2);
    tick();
    check("bp_ready_full", 32'(bus.in_ready), 32'd0);
    drive(ALU_ADD, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 32'h208, 5'd3);
    tick();
    check("bp_third_refused", 32'(bus.in_ready), 32'd0);
    check("bp_head_hold", bus.out_result, 32'h11);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("fifo_first_rd", 32'(bus.out_rd), 32'd1);
    tick();
    check("fifo_second", bus.out_result, 32'h22);
    check("fifo_second_rd", 32'(bus.out_rd), 32'd2);
    tick();
    check("fifo_empty", 32'(bus.out_valid), 32'd0);

    // count==1 with simultaneous push and pop
    drive(ALU_ADD, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20C, 5'd4);
    tick();
    drive(ALU_ADD, 32'h45, 1'b0, 1'b0, 1'b0, 1'b0, 32'h210, 5'd5);
    tick();
    bus.in_valid = 1'b0;
    check("pp_next", bus.out_result, 32'h45);
    check("pp_valid", 32'(bus.out_valid), 32'd1);
    tick();
    check("pp_empty", 32'(bus.out_valid), 32'd0);

    // 5a: flush in RUN drops the offered input
    bus.out_ready = 1'b0;
    drive(ALU_ADD, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 5'd10);
    tick();
    drive(ALU_ADD, 32'h51, 1'b0, 1'b0, 1'b0, 1'b0, 32'h304, 5'd11);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_run_empty", 32'(bus.out_valid), 32'd0);

    // 5b: flush with a pending exception and a full buffer
    drive(ALU_ADD, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0100, 5'd5);
    tick();
    drive(ALU_SUB, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0020, 5'd6);
    tick();
    check("sub_trap", 32'(bus.exc_valid), 32'd1);
    check("pre_flush_head", bus.out_result, 32'h55);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_exc_kept", 32'(bus.exc_valid), 32'd1);
    check("flush_epc_kept", bus.exc_epc, 32'h0040_0020);
    bus.out_ready = 1'b1;
    tick();
    check("flush_still_empty", 32'(bus.out_valid), 32'd0);
    bus.exc_ack = 1'b1;
    tick();
    bus.exc_ack = 1'b0;
    check("ack2_exc_valid", 32'(bus.exc_valid), 32'd0);

    // 6: async reset with full buffer and pending exception
    bus.out_ready = 1'b0;
    drive(ALU_ADD, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0200, 5'd8);
    tick();
    drive(ALU_ADD, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0030, 5'd9);
    tick();
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_exc", 32'(bus.exc_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_result", bus.out_result, 32'd0);
    check("arst_out_rd", 32'(bus.out_rd), 32'd0);
    check("arst_out_rw", 32'(bus.out_reg_write), 32'd0);
    check("arst_exc_valid", 32'(bus.exc_valid), 32'd0);
    check("arst_exc_epc", bus.exc_epc, 32'd0);
    check("arst_exc_cause", 32'(bus.exc_cause), 32'd0);
    #1;
    reset_n = 1'b1;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("arst_stays_empty", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
